// File: rtl/vga_sync_gen.sv
//------------------------------------------------------------------------------
// Module      : vga_sync_gen
// Description : Vertical line counter and registered sync/pixel stage of the
//               VGA path, with lock tracking and upstream line-timing checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic       trig_v,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_H_TOTAL    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       w_update;
  logic [9:0] w_v_eff;
  logic       w_video_next;
  logic       w_hsync_next;
  logic       w_vsync_next;
  logic       w_frame_next;
  logic       w_err_next;

  // Nothing moves until the first line start; the lock edge itself counts.
  assign w_update = locked | trig_v;

  // The lock edge pins the line to 0 instead of advancing.
  always_comb begin
    w_v_eff = v_count;
    if (!locked) begin
      w_v_eff = '0;
    end else if (trig_v) begin
      w_v_eff = (v_count == c_V_LAST) ? '0 : v_count + 10'd1;
    end
  end

  always_comb begin
    w_video_next = (h_count < c_H_VIS) && (w_v_eff < c_V_VIS);
    w_hsync_next = ((h_count >= c_HS_START) && (h_count < c_HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vsync_next = ((w_v_eff >= c_VS_START) && (w_v_eff < c_VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_frame_next = trig_v && (w_v_eff == '0);
    w_err_next   = (trig_v && (h_count != '0))
                 || (h_count >= c_H_TOTAL)
                 || (locked && (h_count == '0) && !trig_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      v_count  <= '0;
      sync_err <= 1'b0;
    end else if (w_update) begin
      locked   <= 1'b1;
      v_count  <= w_v_eff;
      sync_err <= sync_err | w_err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_on   <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
      frame_tick <= 1'b0;
    end else if (w_update) begin
      video_on   <= w_video_next;
      pixel_x    <= w_video_next ? h_count : '0;
      pixel_y    <= w_video_next ? w_v_eff : '0;
      hsync      <= w_hsync_next;
      vsync      <= w_vsync_next;
      frame_tick <= w_frame_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_sync_gen
// Description : Scoreboard bench for vga_sync_gen using a shrunken timing set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_count;
  logic       trig_v;
  logic [9:0] v_count, pixel_x, pixel_y;
  logic       hsync, vsync, video_on, frame_tick, locked, sync_err;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .trig_v(trig_v),
    .v_count(v_count), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v, px, py;
    logic       hs, vs, vid, ft, lk, err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  int   m_line;
  bit   m_locked, m_err;
  exp_t m_out;

  int ft_cnt = 0, hs_low = 0, vs_low = 0, vis5 = 0;

  always @(posedge clk) begin
    #1;
    if (frame_tick === 1'b1) ft_cnt++;
    if (hsync === 1'b0) hs_low++;
    if (vsync === 1'b0) vs_low++;
    if (video_on === 1'b1 && pixel_y === 10'd5) vis5++;
  end

  // Scoreboard: one expected record per driven cycle, popped after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks += 9;
      if (v_count !== e.v)     begin n_fails++; $display("FAIL sb_v_count got %0d want %0d t=%0t", v_count, e.v, $time); end
      if (pixel_x !== e.px)    begin n_fails++; $display("FAIL sb_pixel_x got %0d want %0d t=%0t", pixel_x, e.px, $time); end
      if (pixel_y !== e.py)    begin n_fails++; $display("FAIL sb_pixel_y got %0d want %0d t=%0t", pixel_y, e.py, $time); end
      if (hsync !== e.hs)      begin n_fails++; $display("FAIL sb_hsync got %b want %b t=%0t", hsync, e.hs, $time); end
      if (vsync !== e.vs)      begin n_fails++; $display("FAIL sb_vsync got %b want %b t=%0t", vsync, e.vs, $time); end
      if (video_on !== e.vid)  begin n_fails++; $display("FAIL sb_video_on got %b want %b t=%0t", video_on, e.vid, $time); end
      if (frame_tick !== e.ft) begin n_fails++; $display("FAIL sb_frame_tick got %b want %b t=%0t", frame_tick, e.ft, $time); end
      if (locked !== e.lk)     begin n_fails++; $display("FAIL sb_locked got %b want %b t=%0t", locked, e.lk, $time); end
      if (sync_err !== e.err)  begin n_fails++; $display("FAIL sb_sync_err got %b want %b t=%0t", sync_err, e.err, $time); end
    end
  end

  task automatic model_reset();
    m_line   = 0;
    m_locked = 0;
    m_err    = 0;
    m_out    = '{v: 10'd0, px: 10'd0, py: 10'd0, hs: 1'b1, vs: 1'b1,
                 vid: 1'b0, ft: 1'b0, lk: 1'b0, err: 1'b0};
    sb.delete();
  endtask

  // Drives one cycle at the falling edge and queues what the next rising edge must show.
  task automatic drive(input int h, input bit t);
    int line;
    bit vis;
    @(negedge clk);
    h_count = 10'(h);
    trig_v  = t;
    if (m_locked || t) begin
      if (!m_locked)  line = 0;
      else if (t)     line = (m_line + 1) % VT;
      else            line = m_line;
      if ((t && h != 0) || h >= HT || (m_locked && h == 0 && !t)) m_err = 1;
      vis      = (h < HV) && (line < VV);
      m_locked = 1;
      m_line   = line;
      m_out.v   = 10'(line);
      m_out.vid = vis;
      m_out.px  = vis ? 10'(h) : 10'd0;
      m_out.py  = vis ? 10'(line) : 10'd0;
      m_out.hs  = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
      m_out.vs  = (line >= VV + VF && line < VV + VF + VS) ? 1'b0 : 1'b1;
      m_out.ft  = t && (line == 0);
      m_out.lk  = 1'b1;
      m_out.err = m_err;
    end
    sb.push_back(m_out);
  endtask

  task automatic run_line();
    for (int h = 0; h < HT; h++) drive(h, h == 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    settle();
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    h_count = 10'd300;
    trig_v  = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks += 7;
    if (hsync !== 1'b1)      begin n_fails++; $display("FAIL reset_hsync got %b want 1", hsync); end
    if (vsync !== 1'b1)      begin n_fails++; $display("FAIL reset_vsync got %b want 1", vsync); end
    if (video_on !== 1'b0)   begin n_fails++; $display("FAIL reset_video_on got %b want 0", video_on); end
    if (v_count !== 10'd0)   begin n_fails++; $display("FAIL reset_v_count got %0d want 0", v_count); end
    if (locked !== 1'b0)     begin n_fails++; $display("FAIL reset_locked got %b want 0", locked); end
    if (frame_tick !== 1'b0) begin n_fails++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
    if (sync_err !== 1'b0)   begin n_fails++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    #20;
  endtask

  task automatic test_lock();
    release_reset();
    ft_cnt = 0;
    run_line();
    settle();
    n_checks += 4;
    if (locked !== 1'b1)   begin n_fails++; $display("FAIL lock_locked got %b want 1", locked); end
    if (ft_cnt !== 1)      begin n_fails++; $display("FAIL lock_frame_tick_count got %0d want 1", ft_cnt); end
    if (v_count !== 10'd0) begin n_fails++; $display("FAIL lock_v_count got %0d want 0", v_count); end
    if (video_on !== 1'b0) begin n_fails++; $display("FAIL lock_video_end got %b want 0", video_on); end
  endtask

  task automatic test_hsync();
    repeat (4) run_line();
    hs_low = 0;
    vis5   = 0;
    run_line();
    settle();
    n_checks += 3;
    if (hs_low !== HS)     begin n_fails++; $display("FAIL hsync_low_clocks got %0d want %0d", hs_low, HS); end
    if (vis5 !== HV)       begin n_fails++; $display("FAIL line5_visible_clocks got %0d want %0d", vis5, HV); end
    if (v_count !== 10'd5) begin n_fails++; $display("FAIL hsync_v_count got %0d want 5", v_count); end
  endtask

  task automatic test_vsync_wrap();
    repeat (VT - 6) run_line();
    settle();
    n_checks++;
    if (v_count !== 10'(VT - 1)) begin n_fails++; $display("FAIL wrap_last_line got %0d want %0d", v_count, VT - 1); end
    ft_cnt = 0;
    vs_low = 0;
    repeat (VT) run_line();
    settle();
    n_checks += 2;
    if (ft_cnt !== 1)       begin n_fails++; $display("FAIL frame_tick_per_frame got %0d want 1", ft_cnt); end
    if (vs_low !== VS * HT) begin n_fails++; $display("FAIL vsync_low_clocks got %0d want %0d", vs_low, VS * HT); end
  endtask

  task automatic test_error_trig();
    drive(0, 1'b1);
    drive(1, 1'b0);
    drive(5, 1'b1);
    for (int h = 6; h < HT; h++) drive(h, 1'b0);
    settle();
    n_checks += 2;
    if (sync_err !== 1'b1) begin n_fails++; $display("FAIL err_trig_sticky got %b want 1", sync_err); end
    if (v_count !== 10'd1) begin n_fails++; $display("FAIL err_trig_v_count got %0d want 1", v_count); end
  endtask

  task automatic test_reset_mid();
    repeat (8) run_line();
    for (int h = 0; h < 10; h++) drive(h, h == 0);
    do_reset();
    #1;
    n_checks += 4;
    if (v_count !== 10'd0) begin n_fails++; $display("FAIL mid_reset_v_count got %0d want 0", v_count); end
    if (locked !== 1'b0)   begin n_fails++; $display("FAIL mid_reset_locked got %b want 0", locked); end
    if (sync_err !== 1'b0) begin n_fails++; $display("FAIL mid_reset_sync_err got %b want 0", sync_err); end
    if (video_on !== 1'b0) begin n_fails++; $display("FAIL mid_reset_video_on got %b want 0", video_on); end
    release_reset();
    for (int h = 10; h <= 20; h++) drive(h, 1'b0);
    settle();
    n_checks += 2;
    if (locked !== 1'b0) begin n_fails++; $display("FAIL prelock_locked got %b want 0", locked); end
    if (hsync !== 1'b1)  begin n_fails++; $display("FAIL prelock_hsync got %b want 1", hsync); end
    ft_cnt = 0;
    run_line();
    settle();
    n_checks += 3;
    if (locked !== 1'b1)   begin n_fails++; $display("FAIL relock_locked got %b want 1", locked); end
    if (ft_cnt !== 1)      begin n_fails++; $display("FAIL relock_frame_tick got %0d want 1", ft_cnt); end
    if (v_count !== 10'd0) begin n_fails++; $display("FAIL relock_v_count got %0d want 0", v_count); end
  endtask

  task automatic test_error_missing();
    n_checks++;
    if (sync_err !== 1'b0) begin n_fails++; $display("FAIL missing_pre_err got %b want 0", sync_err); end
    drive(0, 1'b0);
    drive(1, 1'b0);
    settle();
    n_checks += 2;
    if (sync_err !== 1'b1) begin n_fails++; $display("FAIL missing_trig_err got %b want 1", sync_err); end
    if (v_count !== 10'd0) begin n_fails++; $display("FAIL missing_trig_v_count got %0d want 0", v_count); end
  endtask

  task automatic test_error_range();
    do_reset();
    release_reset();
    run_line();
    settle();
    n_checks++;
    if (sync_err !== 1'b0) begin n_fails++; $display("FAIL range_pre_err got %b want 0", sync_err); end
    drive(HT, 1'b0);
    drive(1, 1'b0);
    settle();
    n_checks++;
    if (sync_err !== 1'b1) begin n_fails++; $display("FAIL range_err got %b want 1", sync_err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_hsync();
    test_vsync_wrap();
    test_error_trig();
    test_reset_mid();
    test_error_missing();
    test_error_range();
    settle();
    n_checks++;
    if (sb.size() != 0) begin n_fails++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
